// File: rtl/alu_if.sv
// Operand/opcode request and registered result/flags response bundle for the alu.
interface alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic [2:0]       operation;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             zero;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, operation, data_a, data_b,
        input  result, out_valid, zero, carry, overflow
    );

    modport slave (
        input  in_valid, operation, data_a, data_b,
        output result, out_valid, zero, carry, overflow
    );
endinterface

// File: rtl/alu.sv
// Single-cycle-registered arithmetic/logic unit: combinational compute
// feeding one output register stage for the result and status flags.
module alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_MUL = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_XOR = 3'd7
    } op_e;

    logic [WIDTH-1:0]   a_c;
    logic [WIDTH-1:0]   b_c;
    logic [SHW-1:0]     shamt_c;
    logic [WIDTH:0]     sum_c;
    logic [WIDTH:0]     diff_c;
    logic [2*WIDTH-1:0] prod_c;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d,  carry_q;
    logic             ovf_d,    ovf_q;
    logic             zero_d,   zero_q;
    logic             valid_q;

    assign a_c     = bus.data_a;
    assign b_c     = bus.data_b;
    assign shamt_c = b_c[SHW-1:0];
    // Extra top bit of sum/diff is the carry-out / borrow respectively.
    assign sum_c   = {1'b0, a_c} + {1'b0, b_c};
    assign diff_c  = {1'b0, a_c} - {1'b0, b_c};
    assign prod_c  = (2*WIDTH)'(a_c) * (2*WIDTH)'(b_c);

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        case (op_e'(bus.operation))
            OP_ADD: begin
                result_d = sum_c[WIDTH-1:0];
                carry_d  = sum_c[WIDTH];
                ovf_d    = (a_c[WIDTH-1] == b_c[WIDTH-1]) &&
                           (sum_c[WIDTH-1] != a_c[WIDTH-1]);
            end
            OP_MUL: begin
                result_d = prod_c[WIDTH-1:0];
                ovf_d    = |prod_c[2*WIDTH-1:WIDTH];
            end
            OP_SUB: begin
                result_d = diff_c[WIDTH-1:0];
                carry_d  = diff_c[WIDTH];
                ovf_d    = (a_c[WIDTH-1] != b_c[WIDTH-1]) &&
                           (diff_c[WIDTH-1] != a_c[WIDTH-1]);
            end
            OP_AND:  result_d = a_c & b_c;
            OP_OR:   result_d = a_c | b_c;
            OP_SLL:  result_d = a_c << shamt_c;
            OP_SRL:  result_d = a_c >> shamt_c;
            OP_XOR:  result_d = a_c ^ b_c;
            default: result_d = '0;
        endcase
        zero_d = (result_d == '0);
    end

    // Result and flags only load on a valid cycle; otherwise they hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                result_q <= result_d;
                carry_q  <= carry_d;
                ovf_q    <= ovf_d;
                zero_q   <= zero_d;
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.out_valid = valid_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: vector table plus reset and back-to-back/hold sequences.
module tb_alu;
    logic clk;
    logic rst;

    alu_if #(.WIDTH(32)) bus ();

    alu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    int unsigned total;
    int unsigned bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        bus.in_valid  = v;
        bus.operation = op;
        bus.data_a    = a;
        bus.data_b    = b;
    endtask

    task automatic chk_all(input string nm, input logic [31:0] res, input logic ov,
                           input logic z, input logic c, input logic v);
        chk({nm, "_result"},    bus.result,          res);
        chk({nm, "_out_valid"}, 32'(bus.out_valid),  32'(ov));
        chk({nm, "_zero"},      32'(bus.zero),       32'(z));
        chk({nm, "_carry"},     32'(bus.carry),      32'(c));
        chk({nm, "_overflow"},  32'(bus.overflow),   32'(v));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[19];

    initial begin
        total = 0;
        bad   = 0;

        vecs[0]  = '{3'd0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{3'd1, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{3'd2, 32'h0000_0002, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'd2, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'd2, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{3'd5, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'd5, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'd5, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'd6, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'd6, 32'hFFFF_FFFF, 32'h0000_0020, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{3'd7, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{3'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{3'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hFFFF_0F0F, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{3'd3, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1, 1'b0, 1'b0};

        // Reset held across an edge with a pending operation.
        rst = 1'b1;
        drive(1'b1, 3'd0, 32'd1, 32'd1);
        step();
        chk_all("reset_init", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        step();

        for (int i = 0; i < 19; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].res, 1'b1, vecs[i].z, vecs[i].c, vecs[i].v);
        end

        // Flags from a carry/zero result must hold through idle cycles.
        drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
        step();
        drive(1'b0, 3'd1, 32'h0000_0003, 32'h0000_0005);
        step();
        chk_all("hold_flags", 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Back-to-back ADD then MUL, then two idle cycles.
        drive(1'b1, 3'd0, 32'd1, 32'd2);
        step();
        chk_all("b2b_add", 32'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd1, 32'd3, 32'd4);
        step();
        chk_all("b2b_mul", 32'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        chk_all("b2b_idle1", 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("b2b_idle2", 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with a pending valid operation.
        drive(1'b1, 3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        step();
        chk_all("pre_rst", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 3'd0, 32'd7, 32'd8);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("rst_hold", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk_all("post_rst", 32'd15, 1'b1, 1'b0, 1'b0, 1'b0);

        drive(1'b0, 3'd0, 32'd0, 32'd0);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
